// File: rtl/axi4_slave_wr_arbiter_if.sv
// Request/grant bundle between the crossbar write path and one per-slave write arbiter.
// The master modport is the crossbar side; the slave modport is the arbiter side.
interface axi4_slave_wr_arbiter_if #(
  parameter int MASTER_NUM = 2
);
  localparam int IDX_W = $clog2(MASTER_NUM);

  logic [MASTER_NUM-1:0] aw_req;
  logic                  aw_hs;
  logic                  w_last_hs;
  logic                  b_hs;
  logic [MASTER_NUM-1:0] grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  busy;
  logic                  timeout_err;

  modport master (
    output aw_req, aw_hs, w_last_hs, b_hs,
    input  grant, grant_idx, busy, timeout_err
  );

  modport slave (
    input  aw_req, aw_hs, w_last_hs, b_hs,
    output grant, grant_idx, busy, timeout_err
  );
endinterface

// File: rtl/axi4_slave_wr_arbiter.sv
// Round-robin per-slave AXI4 write arbiter; grant held from AW through WLAST to B (watchdog: AXI4_WR_ARB_TIMEOUT_EN).
// Latency: request in cycle N -> registered grant in N+1. Backpressure: holds grant until b_hs, ignores new requests meanwhile.
module axi4_slave_wr_arbiter #(
  parameter int MASTER_NUM  = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                    clk,
  input logic                    rst,
  axi4_slave_wr_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(MASTER_NUM);

  if (MASTER_NUM < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("axi4_slave_wr_arbiter: MASTER_NUM must be >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [IDX_W-1:0]      win;
  logic                  found;
  logic                  busy_q, busy_d;
  logic                  w_done_q, w_done_d;

`ifdef AXI4_WR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             to_q;
  logic             fire;
`endif

  // Two passes give "first requester at or after rr_ptr" with wrap-around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int j = 0; j < MASTER_NUM; j++) begin
      if (!found && bus.aw_req[j] && j >= int'(rr_q)) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
    for (int j = 0; j < MASTER_NUM; j++) begin
      if (!found && bus.aw_req[j]) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    rr_d     = rr_q;
    w_done_d = w_done_q;
`ifdef AXI4_WR_ARB_TIMEOUT_EN
    fire     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ADDR;
          grant_d = MASTER_NUM'(1) << win;
          idx_d   = win;
          busy_d  = 1'b1;
          rr_d    = (win == IDX_W'(MASTER_NUM - 1)) ? '0 : win + 1'b1;
        end
      end
      ADDR: begin
        // W may complete before AW; remember it so AW can skip DATA.
        if (bus.aw_hs && (bus.w_last_hs || w_done_q)) begin
          state_d  = RESP;
          w_done_d = 1'b0;
        end else if (bus.aw_hs) begin
          state_d = DATA;
        end else if (bus.w_last_hs) begin
          w_done_d = 1'b1;
        end
      end
      DATA: begin
        if (bus.w_last_hs) state_d = RESP;
      end
      RESP: begin
        if (bus.b_hs) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AXI4_WR_ARB_TIMEOUT_EN
    // A real transition in the expiry cycle takes precedence over the watchdog.
    if (state_q != IDLE && state_d == state_q && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
      state_d  = IDLE;
      grant_d  = '0;
      idx_d    = '0;
      busy_d   = 1'b0;
      w_done_d = 1'b0;
      fire     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_q     <= '0;
      busy_q   <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      busy_q   <= busy_d;
      w_done_q <= w_done_d;
    end
  end

`ifdef AXI4_WR_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
      to_q  <= fire;
    end
  end

  assign bus.timeout_err = to_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.grant     = grant_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_axi4_slave_wr_arbiter.sv
// Bench for axi4_slave_wr_arbiter: transaction-level owner/progress model compared every cycle,
// plus directed literal expectations and a randomized run.
module tb_axi4_slave_wr_arbiter;
  localparam int N  = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  axi4_slave_wr_arbiter_if #(.MASTER_NUM(N)) bus ();

  axi4_slave_wr_arbiter #(.MASTER_NUM(N), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: which master owns the slave, whether its AW and its final W beat have been seen.
  int own   = -1;
  int ptr   = 0;
  bit aw_s  = 1'b0;
  bit w_s   = 1'b0;
  bit e_to  = 1'b0;
  bit prog  = 1'b0;
  int stall = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      own = -1; ptr = 0; aw_s = 1'b0; w_s = 1'b0; e_to = 1'b0; stall = 0;
    end else begin
      e_to = 1'b0;
      prog = 1'b0;
      if (own < 0) begin
        for (int k = 0; k < N; k++) begin
          if (own < 0 && bus.aw_req[(ptr + k) % N]) own = (ptr + k) % N;
        end
        if (own >= 0) begin
          ptr = (own + 1) % N; aw_s = 1'b0; w_s = 1'b0; stall = 0;
        end
      end else begin
        if (aw_s && w_s) begin
          if (bus.b_hs) begin own = -1; prog = 1'b1; end
        end else if (aw_s) begin
          if (bus.w_last_hs) begin w_s = 1'b1; prog = 1'b1; end
        end else begin
          if (bus.w_last_hs) w_s = 1'b1;
          if (bus.aw_hs) begin aw_s = 1'b1; prog = 1'b1; end
        end
        if (prog) stall = 0;
        else stall++;
`ifdef AXI4_WR_ARB_TIMEOUT_EN
        if (own >= 0 && stall == TO) begin own = -1; e_to = 1'b1; end
`endif
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  logic [N-1:0] eg;
  always @(negedge clk) begin
    if (!rst) begin
      eg = '0;
      if (own >= 0) eg[own] = 1'b1;
      chk("model grant", int'(bus.grant), int'(eg));
      chk("model busy", int'(bus.busy), (own >= 0) ? 1 : 0);
      chk("model grant_idx", int'(bus.grant_idx), (own >= 0) ? own : 0);
      chk("model timeout_err", int'(bus.timeout_err), int'(e_to));
    end
  end

  task automatic step(input logic [N-1:0] req, input logic aw, input logic wl, input logic b);
    bus.aw_req = req; bus.aw_hs = aw; bus.w_last_hs = wl; bus.b_hs = b;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step('0, 0, 0, 0);
    step('0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic txn(input logic [N-1:0] req, input int exp_g, input string tag);
    step(req, 0, 0, 0);
    chk({tag, " granted"}, int'(bus.grant), exp_g);
    step(req, 1, 0, 0);
    chk({tag, " held after aw"}, int'(bus.grant), exp_g);
    step(req, 0, 1, 0);
    chk({tag, " held after wlast"}, int'(bus.grant), exp_g);
    step(req, 0, 0, 1);
    chk({tag, " released"}, int'(bus.grant), 0);
  endtask

  initial begin
    bus.aw_req = '0; bus.aw_hs = 1'b0; bus.w_last_hs = 1'b0; bus.b_hs = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    do_reset();
    chk("reset grant", int'(bus.grant), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset idx", int'(bus.grant_idx), 0);
    chk("reset timeout", int'(bus.timeout_err), 0);

    // Single transaction, then rr_ptr must point at master 1.
    step(2'b01, 0, 0, 0);
    chk("t1 grant", int'(bus.grant), 1);
    chk("t1 busy", int'(bus.busy), 1);
    step('0, 1, 0, 0);
    step('0, 0, 1, 0);
    step('0, 0, 0, 1);
    chk("t1 released", int'(bus.grant), 0);
    chk("t1 busy low", int'(bus.busy), 0);
    step(2'b11, 0, 0, 0);
    chk("t1 rr_ptr=1", int'(bus.grant), 2);
    chk("t1 idx", int'(bus.grant_idx), 1);
    step('0, 1, 0, 0); step('0, 0, 1, 0); step('0, 0, 0, 1);

    // Round robin with both requesting.
    do_reset();
    txn(2'b11, 1, "t2 first");
    txn(2'b11, 2, "t2 second");
    txn(2'b11, 1, "t2 third");

    // W before AW: ADDR goes straight to RESP.
    step(2'b10, 0, 0, 0);
    chk("t3 grant", int'(bus.grant), 2);
    step('0, 0, 1, 0);
    step('0, 0, 0, 0);
    step('0, 1, 0, 0);
    chk("t3 held", int'(bus.grant), 2);
    step('0, 0, 0, 1);
    chk("t3 no data visit", int'(bus.grant), 0);

    // aw+wlast together; stray b_hs in ADDR/DATA; all three at once.
    step(2'b01, 0, 0, 0);
    step('0, 1, 1, 0);
    step('0, 0, 0, 1);
    chk("t4 aw+wl to resp", int'(bus.grant), 0);
    step(2'b01, 0, 0, 0);
    step('0, 0, 0, 1);
    chk("t4 b in addr ignored", int'(bus.grant), 1);
    step('0, 1, 0, 0);
    step('0, 0, 0, 1);
    chk("t4 b in data ignored", int'(bus.grant), 1);
    step('0, 0, 1, 0);
    step('0, 0, 0, 1);
    chk("t4 done", int'(bus.grant), 0);
    step(2'b01, 0, 0, 0);
    step('0, 1, 1, 1);
    chk("t4 b not consumed", int'(bus.grant), 1);
    step('0, 0, 0, 1);
    chk("t4 triple done", int'(bus.grant), 0);

    // Asynchronous reset in DATA.
    step(2'b10, 0, 0, 0);
    step('0, 1, 0, 0);
    chk("t5 in data", int'(bus.grant), 2);
    #2 rst = 1'b1;
    #1;
    chk("t5 async grant", int'(bus.grant), 0);
    chk("t5 async busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    step(2'b10, 0, 0, 0);
    chk("t5 regrant", int'(bus.grant), 2);
    chk("t5 regrant idx", int'(bus.grant_idx), 1);
    step('0, 1, 0, 0); step('0, 0, 1, 0); step('0, 0, 0, 1);

    // Stalled master: watchdog or indefinite hold.
    step(2'b01, 0, 0, 0);
`ifdef AXI4_WR_ARB_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) step('0, 0, 0, 0);
    chk("t6 before expiry", int'(bus.grant), 1);
    chk("t6 no early pulse", int'(bus.timeout_err), 0);
    step('0, 0, 0, 0);
    chk("t6 timeout pulse", int'(bus.timeout_err), 1);
    chk("t6 grant dropped", int'(bus.grant), 0);
    step('0, 0, 0, 0);
    chk("t6 pulse one cycle", int'(bus.timeout_err), 0);
`else
    for (int i = 0; i < 100; i++) step('0, 0, 0, 0);
    chk("t6 held at 100", int'(bus.grant), 1);
    chk("t6 busy at 100", int'(bus.busy), 1);
    chk("t6 no timeout", int'(bus.timeout_err), 0);
    step('0, 1, 0, 0); step('0, 0, 1, 0); step('0, 0, 0, 1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step(N'($urandom_range(0, (1 << N) - 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
